serial_add_seq: RTL and testbench

SERIAL_ADD_SEQ -- requirements
Module: serial_add_seq

---
 rtl/serial_add_seq_pkg.sv | 16 +
 rtl/serial_add_seq_two_bit_adder.sv | 12 +
 rtl/serial_add_seq.sv | 120 ++++++++++++
 tb/tb_serial_add_seq.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_add_seq_pkg.sv
// Shared types and constants for the 2-bit-per-cycle serial adder.
package serial_add_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    RUN  = 2'b01,
    DONE = 2'b10
  } state_t;

  localparam int DEF_WIDTH = 8;

  function automatic int idx_bits(input int half);
    return (half > 1) ? $clog2(half) : 1;
  endfunction

endpackage

// File: rtl/serial_add_seq_two_bit_adder.sv
// 2-bit ripple slice shared by every step of the serial addition.
module twoBitAdder (
  input  logic [1:0] A,
  input  logic [1:0] B,
  input  logic       Cin,
  output logic [1:0] S,
  output logic       Cout
);

  assign {Cout, S} = {1'b0, A} + {1'b0, B} + {2'b00, Cin};

endmodule

// File: rtl/serial_add_seq.sv
// Serial adder: WIDTH/2 cycles through one 2-bit slice, IDLE/RUN/DONE FSM.
module serial_add_seq
  import serial_add_seq_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int HALF = WIDTH / 2;
  localparam int IW   = idx_bits(HALF);

  state_t           state, state_n;
  logic [IW-1:0]    idx;
  logic             carry;
  logic [WIDTH-1:0] a_q, b_q, sum_q, sum_n;
  logic             cout_q, busy_q;
  logic [1:0]       rst_sync;
  logic             rst_ok;
  logic [1:0]       a_sl, b_sl, s_sl;
  logic             c_sl, last;

  // assert asynchronously, release two edges after rst_n rises
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync <= 2'b00;
    else        rst_sync <= {rst_sync[0], 1'b1};
  end

  assign rst_ok = rst_sync[1];

  always_comb begin
    a_sl = 2'b00;
    b_sl = 2'b00;
    for (int i = 0; i < HALF; i++) begin
      if (idx == IW'(i)) begin
        a_sl = a_q[2*i +: 2];
        b_sl = b_q[2*i +: 2];
      end
    end
  end

  twoBitAdder u_slice (
    .A    (a_sl),
    .B    (b_sl),
    .Cin  (carry),
    .S    (s_sl),
    .Cout (c_sl)
  );

  always_comb begin
    sum_n = sum_q;
    for (int i = 0; i < HALF; i++) begin
      if (idx == IW'(i)) sum_n[2*i +: 2] = s_sl;
    end
  end

  assign last = (idx == IW'(HALF - 1));

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (last)  state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      busy_q <= 1'b0;
    end else if (!rst_ok) begin
      state  <= IDLE;
      idx    <= '0;
      carry  <= 1'b0;
      a_q    <= '0;
      b_q    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state  <= state_n;
      busy_q <= (state_n != IDLE);
      if (state == IDLE && start) begin
        a_q   <= a;
        b_q   <= b;
        carry <= cin;
        idx   <= '0;
        sum_q <= '0;
      end else if (state == RUN) begin
        sum_q <= sum_n;
        carry <= c_sl;
        idx   <= last ? '0 : idx + IW'(1);
        if (last) cout_q <= c_sl;
      end
    end
  end

  assign busy = busy_q;
  assign done = (state == DONE);
  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed self-checking bench for serial_add_seq (WIDTH=8 and WIDTH=4).
module tb_serial_add_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start, cin;
  logic [7:0] a, b;
  logic       busy, done, cout;
  logic [7:0] sum;

  logic       start4, cin4;
  logic [3:0] a4, b4;
  logic       busy4, done4, cout4;
  logic [3:0] sum4;

  int pass_cnt = 0;
  int total    = 0;

  always #5 clk = ~clk;

  serial_add_seq #(.WIDTH(8)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
  );

  serial_add_seq #(.WIDTH(4)) dut4 (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start4),
    .a     (a4),
    .b     (b4),
    .cin   (cin4),
    .busy  (busy4),
    .done  (done4),
    .sum   (sum4),
    .cout  (cout4)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Launch one op, wait for done (bounded), then step into IDLE.
  task automatic do_op(input logic [7:0] av, input logic [7:0] bv,
                       input logic cv, output int lat, output int bcnt);
    a = av;
    b = bv;
    cin = cv;
    start = 1'b1;
    tick();
    start = 1'b0;
    lat = 0;
    bcnt = busy ? 1 : 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
      bcnt += busy ? 1 : 0;
    end
    tick();
    bcnt += busy ? 1 : 0;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    start = 1'b0;
    a = 8'h00;
    b = 8'h00;
    cin = 1'b0;
    start4 = 1'b0;
    a4 = 4'h0;
    b4 = 4'h0;
    cin4 = 1'b0;
    tick();
    tick();
    total++;
    if ({busy, done, cout, sum} !== 11'd0) begin
      $display("FAIL reset_outputs: got busy=%b done=%b cout=%b sum=%h, want all 0",
               busy, done, cout, sum);
    end else pass_cnt++;
    total++;
    if ({busy4, done4, cout4, sum4} !== 7'd0) begin
      $display("FAIL reset_outputs_w4: got %b, want 0",
               {busy4, done4, cout4, sum4});
    end else pass_cnt++;
    rst_n = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_ff_plus_01;
    int lat, bcnt;
    do_op(8'hFF, 8'h01, 1'b0, lat, bcnt);
    total++;
    if (lat != 4) $display("FAIL ff01_latency: got %0d, want 4", lat);
    else pass_cnt++;
    total++;
    if (sum !== 8'h00) $display("FAIL ff01_sum: got %h, want 00", sum);
    else pass_cnt++;
    total++;
    if (cout !== 1'b1) $display("FAIL ff01_cout: got %b, want 1", cout);
    else pass_cnt++;
    total++;
    if (bcnt != 5) $display("FAIL ff01_busy_cycles: got %0d, want 5", bcnt);
    else pass_cnt++;
    total++;
    if (done !== 1'b0) $display("FAIL ff01_done_width: got %b, want 0", done);
    else pass_cnt++;
  endtask

  task automatic test_vectors;
    int lat, bcnt;
    do_op(8'hA5, 8'h5A, 1'b1, lat, bcnt);
    total++;
    if ({cout, sum} !== 9'h100)
      $display("FAIL a5_5a_c1: got %b_%h, want 1_00", cout, sum);
    else pass_cnt++;
    do_op(8'h12, 8'h34, 1'b0, lat, bcnt);
    total++;
    if ({cout, sum} !== 9'h046)
      $display("FAIL 12_34: got %b_%h, want 0_46", cout, sum);
    else pass_cnt++;
    a = 8'hEE;
    b = 8'hDD;
    cin = 1'b1;
    repeat (4) tick();
    total++;
    if ({cout, sum, busy} !== {1'b0, 8'h46, 1'b0})
      $display("FAIL idle_hold: got %b_%h busy=%b, want 0_46 busy=0",
               cout, sum, busy);
    else pass_cnt++;
  endtask

  task automatic test_start_held;
    int dcnt, lat;
    a = 8'h40;
    b = 8'h30;
    cin = 1'b0;
    start = 1'b1;
    tick();
    a = 8'h00;
    b = 8'h00;
    dcnt = 0;
    lat = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    dcnt += done ? 1 : 0;
    total++;
    if ({cout, sum} !== 9'h070 || lat != 4)
      $display("FAIL held_first_result: got %b_%h lat=%0d, want 0_70 lat=4",
               cout, sum, lat);
    else pass_cnt++;
    tick();
    dcnt += done ? 1 : 0;
    total++;
    if (busy !== 1'b0 || dcnt != 1)
      $display("FAIL held_one_done: busy=%b pulses=%0d, want busy=0 pulses=1",
               busy, dcnt);
    else pass_cnt++;
    tick();
    start = 1'b0;
    total++;
    if (busy !== 1'b1 || sum !== 8'h00)
      $display("FAIL held_second_accept: busy=%b sum=%h, want busy=1 sum=00",
               busy, sum);
    else pass_cnt++;
    lat = 0;
    while (!done && lat < 20) begin
      tick();
      lat++;
    end
    total++;
    if ({cout, sum} !== 9'h000 || lat != 4)
      $display("FAIL held_second_result: got %b_%h lat=%0d, want 0_00 lat=4",
               cout, sum, lat);
    else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid_run;
    int lat, bcnt, dseen;
    a = 8'hFF;
    b = 8'hFF;
    cin = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({busy, done, cout, sum} !== 11'd0)
      $display("FAIL midrun_reset: got busy=%b done=%b cout=%b sum=%h, want 0",
               busy, done, cout, sum);
    else pass_cnt++;
    dseen = 0;
    repeat (3) begin
      tick();
      dseen += done ? 1 : 0;
    end
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      dseen += done ? 1 : 0;
    end
    total++;
    if (dseen != 0) $display("FAIL midrun_no_done: got %0d pulses, want 0", dseen);
    else pass_cnt++;
    do_op(8'h03, 8'h04, 1'b0, lat, bcnt);
    total++;
    if ({cout, sum} !== 9'h007 || lat != 4)
      $display("FAIL post_reset_op: got %b_%h lat=%0d, want 0_07 lat=4",
               cout, sum, lat);
    else pass_cnt++;
  endtask

  task automatic test_sweep4;
    int lat;
    logic [4:0] exp;
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          a4 = 4'(ia);
          b4 = 4'(ib);
          cin4 = 1'(ic);
          exp = 5'(ia + ib + ic);
          start4 = 1'b1;
          tick();
          start4 = 1'b0;
          lat = 0;
          while (!done4 && lat < 10) begin
            tick();
            lat++;
          end
          total++;
          if ({cout4, sum4} !== exp || lat != 2)
            $display("FAIL sweep4 a=%h b=%h c=%0d: got %h lat=%0d, want %h lat=2",
                     a4, b4, ic, {cout4, sum4}, lat, exp);
          else pass_cnt++;
          tick();
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_ff_plus_01();
    test_vectors();
    test_start_held();
    test_reset_mid_run();
    test_sweep4();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
